// File: rtl/branch_sequencer_if.sv
// Decoder/PC-datapath side of the 6502 relative-branch sequencer.
// The master drives the decoder inputs; the slave (the sequencer) drives strobes and flags.
interface branch_sequencer_if;
   logic       ready;
   logic       start;
   logic [2:0] opcode_hi;
   logic       flag_n;
   logic       flag_v;
   logic       flag_c;
   logic       flag_z;
   logic [7:0] offset;
   logic [7:0] pcl;
   logic       busy;
   logic       taken;
   logic       pcl_load;
   logic [7:0] pcl_new;
   logic       pch_inc;
   logic       pch_dec;
   logic       branch_forward;
   logic       branch_backward;
   logic       done;

   modport master (
      output ready, start, opcode_hi, flag_n, flag_v, flag_c, flag_z, offset, pcl,
      input  busy, taken, pcl_load, pcl_new, pch_inc, pch_dec,
             branch_forward, branch_backward, done
   );

   modport slave (
      input  ready, start, opcode_hi, flag_n, flag_v, flag_c, flag_z, offset, pcl,
      output busy, taken, pcl_load, pcl_new, pch_inc, pch_dec,
             branch_forward, branch_backward, done
   );
endinterface

// File: rtl/branch_sequencer.sv
// 6502 relative-branch sequencer: condition evaluation, PCL add and optional PCH fix-up.
// Strobes are decoded from the registered state and qualified by ready and rst.
module branch_sequencer (
   input  logic                clk,
   input  logic                rst,
   branch_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      ADD  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t     state_r;
   logic [7:0] offset_r;
   logic [7:0] pcl_r;
   logic       taken_r;
   logic       fwd_r;
   logic       bwd_r;

   logic       flag_sel_s;
   logic [8:0] sum_s;
   logic       cross_s;
   logic       go_s;
   logic       pcl_load_s;
   logic       pch_inc_s;
   logic       pch_dec_s;
   logic       done_s;

   // Branch condition flag selected by opcode bits 7:6.
   always_comb begin
      case (bus.opcode_hi[2:1])
         2'b00:   flag_sel_s = bus.flag_n;
         2'b01:   flag_sel_s = bus.flag_v;
         2'b10:   flag_sel_s = bus.flag_c;
         2'b11:   flag_sel_s = bus.flag_z;
         default: flag_sel_s = bus.flag_z;
      endcase
   end

   // PCL add on captured operands; a page is crossed when carry disagrees with offset sign.
   always_comb begin
      sum_s   = {1'b0, pcl_r} + {1'b0, offset_r};
      cross_s = offset_r[7] ^ sum_s[8];
   end

   // Sequencer state, operand capture and registered decision/direction flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         offset_r <= 8'h00;
         pcl_r    <= 8'h00;
         taken_r  <= 1'b0;
         fwd_r    <= 1'b0;
         bwd_r    <= 1'b0;
      end else if (bus.ready) begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  offset_r <= bus.offset;
                  pcl_r    <= bus.pcl;
                  taken_r  <= (flag_sel_s == bus.opcode_hi[0]);
                  fwd_r    <= 1'b0;
                  bwd_r    <= 1'b0;
                  state_r  <= EVAL;
               end else begin
                  state_r  <= IDLE;
               end
            end
            EVAL: begin
               if (taken_r) begin
                  state_r <= ADD;
               end else begin
                  state_r <= IDLE;
               end
            end
            ADD: begin
               if (cross_s) begin
                  fwd_r   <= ~offset_r[7];
                  bwd_r   <= offset_r[7];
                  state_r <= FIX;
               end else begin
                  state_r <= IDLE;
               end
            end
            FIX: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   // One-shot strobes: only on the cycle the state actually advances, never under reset.
   always_comb begin
      go_s       = bus.ready & ~rst;
      pcl_load_s = 1'b0;
      pch_inc_s  = 1'b0;
      pch_dec_s  = 1'b0;
      done_s     = 1'b0;
      case (state_r)
         IDLE: begin
            done_s = 1'b0;
         end
         EVAL: begin
            done_s = go_s & ~taken_r;
         end
         ADD: begin
            pcl_load_s = go_s;
            done_s     = go_s & ~cross_s;
         end
         FIX: begin
            pch_inc_s = go_s & fwd_r;
            pch_dec_s = go_s & bwd_r;
            done_s    = go_s;
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   assign bus.busy            = (state_r != IDLE);
   assign bus.taken           = taken_r;
   assign bus.pcl_new         = sum_s[7:0];
   assign bus.pcl_load        = pcl_load_s;
   assign bus.pch_inc         = pch_inc_s;
   assign bus.pch_dec         = pch_dec_s;
   assign bus.branch_forward  = fwd_r;
   assign bus.branch_backward = bwd_r;
   assign bus.done            = done_s;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: table of branch vectors plus stall and reset sequences.
// Expected per-cycle outputs are queued with the stimulus and popped as each cycle is sampled.
module tb_branch_sequencer;

   logic clk;
   logic rst;

   branch_sequencer_if bus ();

   branch_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [3:0] nvcz;
      logic [7:0] off;
      logic [7:0] pcl;
      logic       tk;
      logic [7:0] nw;
      logic [1:0] dir;   // {forward, backward} when the page is crossed
   } vec_t;

   typedef struct {
      logic        rdy;
      logic        st;
      logic        rs;
      logic        chk;
      logic [15:0] exp;
      int          tag;
   } step_t;

   vec_t  vecs [14];
   step_t step_q [$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_load   = 0;
   int    n_inc    = 0;
   int    n_dec    = 0;
   int    n_done   = 0;

   function automatic logic [15:0] ex(input logic b, input logic t, input logic l,
                                      input logic i, input logic d, input logic dn,
                                      input logic f, input logic bk, input logic [7:0] nw);
      return {b, t, l, i, d, dn, f, bk, nw};
   endfunction

   function automatic void push(input logic rdy, input logic st, input logic rs,
                                input logic chk, input logic [15:0] e, input int tag);
      step_t s;
      s.rdy = rdy; s.st = st; s.rs = rs; s.chk = chk; s.exp = e; s.tag = tag;
      step_q.push_back(s);
   endfunction

   task automatic check(input string name, input int tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s tag=%0d: got %h expected %h", name, tag, act, exp);
      end
   endtask

   // Apply queued steps; outputs sampled 1 time unit after the falling edge.
   task automatic drain();
      step_t       s;
      logic [15:0] act;
      while (step_q.size() > 0) begin
         s = step_q.pop_front();
         @(negedge clk);
         bus.ready = s.rdy;
         bus.start = s.st;
         rst       = s.rs;
         #1;
         act = {bus.busy, bus.taken, bus.pcl_load, bus.pch_inc, bus.pch_dec, bus.done,
                bus.branch_forward, bus.branch_backward, bus.pcl_new};
         n_load += int'(bus.pcl_load);
         n_inc  += int'(bus.pch_inc);
         n_dec  += int'(bus.pch_dec);
         n_done += int'(bus.done);
         if (s.chk) check("cycle", s.tag, {16'h0000, act}, {16'h0000, s.exp});
      end
   endtask

   task automatic set_inputs(input vec_t v);
      bus.opcode_hi = v.op;
      {bus.flag_n, bus.flag_v, bus.flag_c, bus.flag_z} = v.nvcz;
      bus.offset = v.off;
      bus.pcl    = v.pcl;
   endtask

   task automatic run_vector(input vec_t v, input int tag);
      logic f;
      logic b;
      logic x;
      f = v.dir[1];
      b = v.dir[0];
      x = f | b;
      set_inputs(v);
      push(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, tag);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, v.tk, 1'b0, 1'b0, 1'b0, ~v.tk, 1'b0, 1'b0, v.nw), tag);
      if (v.tk) begin
         push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ~x, 1'b0, 1'b0, v.nw), tag);
         if (x) begin
            push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, f, b, 1'b1, f, b, v.nw), tag);
         end
      end
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b0, v.tk, 1'b0, 1'b0, 1'b0, 1'b0, f & v.tk, b & v.tk, v.nw), tag);
      drain();
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      bus.ready = 1'b0;
      bus.start = 1'b0;
      bus.opcode_hi = 3'b000;
      {bus.flag_n, bus.flag_v, bus.flag_c, bus.flag_z} = 4'b0000;
      bus.offset = 8'h00;
      bus.pcl    = 8'h00;

      vecs[0]  = '{3'b110, 4'b1111, 8'h10, 8'h20, 1'b0, 8'h30, 2'b00};  // BNE, Z=1
      vecs[1]  = '{3'b111, 4'b0001, 8'h10, 8'h20, 1'b1, 8'h30, 2'b00};  // BEQ same page
      vecs[2]  = '{3'b101, 4'b0010, 8'h10, 8'hF8, 1'b1, 8'h08, 2'b10};  // BCS forward cross
      vecs[3]  = '{3'b001, 4'b1000, 8'hF0, 8'h05, 1'b1, 8'hF5, 2'b01};  // BMI backward cross
      vecs[4]  = '{3'b001, 4'b1000, 8'hFE, 8'h05, 1'b1, 8'h03, 2'b00};  // BMI same page
      vecs[5]  = '{3'b000, 4'b0111, 8'h7F, 8'h80, 1'b1, 8'hFF, 2'b00};  // BPL +127 no cross
      vecs[6]  = '{3'b000, 4'b0111, 8'h7F, 8'h81, 1'b1, 8'h00, 2'b10};  // BPL +127 cross
      vecs[7]  = '{3'b011, 4'b1011, 8'h80, 8'h00, 1'b0, 8'h80, 2'b00};  // BVS, V=0
      vecs[8]  = '{3'b010, 4'b1011, 8'h80, 8'h80, 1'b1, 8'h00, 2'b00};  // BVC -128 no cross
      vecs[9]  = '{3'b010, 4'b0000, 8'h80, 8'h7F, 1'b1, 8'hFF, 2'b01};  // BVC -128 cross
      vecs[10] = '{3'b100, 4'b0010, 8'h01, 8'hFF, 1'b0, 8'h00, 2'b00};  // BCC, C=1
      vecs[11] = '{3'b100, 4'b1101, 8'h00, 8'h44, 1'b1, 8'h44, 2'b00};  // BCC zero offset
      vecs[12] = '{3'b110, 4'b1110, 8'h02, 8'hFE, 1'b1, 8'h00, 2'b10};  // BNE forward cross
      vecs[13] = '{3'b011, 4'b0100, 8'h05, 8'h10, 1'b1, 8'h15, 2'b00};  // BVS, V=1

      // Reset state.
      push(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0);
      push(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0);
      push(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 0);
      drain();

      for (int i = 0; i < 14; i++) begin
         run_vector(vecs[i], 100 + i);
      end

      // Page-cross BCS with stalls in ADD and FIX; start pulses while busy are ignored.
      set_inputs(vecs[2]);
      push(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 200);
      drain();
      n_load = 0; n_inc = 0; n_dec = 0; n_done = 0;
      push(1'b1, 1'b1, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08), 201);
      push(1'b0, 1'b1, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08), 202);
      push(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08), 203);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08), 204);
      push(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08), 205);
      push(1'b0, 1'b1, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08), 206);
      push(1'b0, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08), 207);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h08), 208);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08), 209);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08), 210);
      drain();
      check("stall_pcl_load_count", 211, n_load, 1);
      check("stall_pch_inc_count", 212, n_inc, 1);
      check("stall_pch_dec_count", 213, n_dec, 0);
      check("stall_done_count", 214, n_done, 1);

      // Reset asserted while in FIX: no pch strobe, everything cleared next cycle.
      set_inputs(vecs[2]);
      n_inc = 0; n_dec = 0; n_done = 0;
      push(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 300);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08), 301);
      push(1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08), 302);
      push(1'b1, 1'b0, 1'b1, 1'b1, ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08), 303);
      push(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 304);
      drain();
      check("reset_pch_inc_count", 305, n_inc, 0);
      check("reset_done_count", 306, n_done, 0);
      run_vector('{3'b010, 4'b1011, 8'hF0, 8'h05, 1'b1, 8'hF5, 2'b01}, 307);  // BVC after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Controls 6502 relative-branch execution (BPL/BMI/BVC/BVS/BCC/BCS/BNE/BEQ) in the control logic.
- Evaluates the branch condition against the status flags, then steps through the PCL add and the optional PCH fix-up.
- Drives PC load/increment/decrement strobes and the forward/backward direction flags that the branch-direction flip-flops consume.
- Sits between the instruction decoder and the PC datapath.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ready  in  1  CPU RDY / step enable; low = stall, hold state
- start  in  1  decoder pulse: branch opcode decoded and offset byte valid
- opcode_hi  in  3  opcode bits 7:5; [2:1] select flag (00 N, 01 V, 10 C, 11 Z); [0] required flag value
- flag_n, flag_v, flag_c, flag_z  in  1 each  current status flags
- offset  in  8  signed relative offset (two's complement)
- pcl  in  8  PCL of the next sequential instruction
- busy  out  1  high in any state other than IDLE
- taken  out  1  registered branch decision
- pcl_load  out  1  strobe: load pcl_new into PCL
- pcl_new  out  8  (captured pcl + captured offset) mod 256
- pch_inc  out  1  strobe: PCH += 1
- pch_dec  out  1  strobe: PCH -= 1
- branch_forward  out  1  page-cross direction flag, forward
- branch_backward  out  1  page-cross direction flag, backward
- done  out  1  one-cycle pulse: branch complete, next opcode fetch may begin

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All outputs 0, including taken, pcl_new, branch_forward and branch_backward. Capture registers cleared.
- rst has priority over every other input. Reset mid-sequence aborts the branch with no strobe issued.
- States: IDLE, EVAL, ADD, FIX. Transitions occur only when ready=1. When ready=0, state and registers hold and pcl_load, pch_inc, pch_dec and done are forced 0.
- IDLE, start=1 and ready=1:
  - capture offset and pcl
  - taken <= (selected flag == opcode_hi[0])
  - clear branch_forward and branch_backward
  - go to EVAL
- start is ignored in all other states.
- EVAL:
  - if taken=0: done=1, go to IDLE
  - else go to ADD
- ADD:
  - pcl_load=1; pcl_new = low 8 bits of the 9-bit sum pcl+offset; c8 = carry out
  - cross = (offset[7]=0 and c8=1) or (offset[7]=1 and c8=0)
  - if cross=0: done=1, go to IDLE
  - if cross=1: register branch_forward=~offset[7] and branch_backward=offset[7], go to FIX
- FIX: pch_inc=branch_forward, pch_dec=branch_backward, done=1, go to IDLE.
- Latency from the start edge to the done cycle, with ready held high:
  - not taken: 1 cycle
  - taken, same page: 2 cycles
  - taken, page cross: 3 cycles
  - This matches 6502 branch timing of 2/3/4 cycles.
- pcl_new is combinational from the captured values. It is stable from EVAL onward and holds until the next start.
- branch_forward and branch_backward hold until the next accepted start. They are never both 1.
- taken holds until the next accepted start.
- pch_inc and pch_dec are mutually exclusive and asserted only in FIX.
- Offset 0x80 (-128) and 0x7F (+127) use the same rules. No special case.
- Each strobe is issued exactly once per branch, regardless of stall length.

Test Plan:
- BNE (opcode_hi=3'b110), flag_z=1, offset=0x10, pcl=0x20 -> taken=0, done 1 cycle after start; no pcl_load, pch_inc or pch_dec.
- BEQ (3'b111), flag_z=1, offset=0x10, pcl=0x20 -> EVAL, then ADD with pcl_load=1, pcl_new=0x30; done in ADD (2 cycles); direction flags 0.
- BCS (3'b101), flag_c=1, offset=0x10, pcl=0xF8 -> ADD: pcl_new=0x08. FIX: pch_inc=1, branch_forward=1, branch_backward=0. done at 3 cycles.
- BMI (3'b001), flag_n=1, offset=0xF0, pcl=0x05 -> ADD: pcl_new=0xF5 (c8=0, cross). FIX: pch_dec=1, branch_backward=1. Same-page check: offset=0xFE, pcl=0x05 gives pcl_new=0x03, no FIX.
- Page-cross branch with ready dropped for 2 cycles in ADD and 3 in FIX -> state frozen, strobes low while stalled; pcl_load, pch_inc and done each pulse exactly once after ready returns. A start pulse during busy is ignored.
- rst=1 asserted in FIX -> next cycle IDLE with all outputs 0 and no pch strobe issued. A subsequent BVC (3'b010) with flag_v=0 sequences normally.
